trd_sched: RTL

//  Thread scheduler for the 8-thread barrel core. Tracks which hardware threads are

---
 rtl/trd_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/trd_sched.sv
// trd_sched: thread scheduler for the 8-thread barrel core.
// Keeps the active-thread set, issues one active thread per cycle in
// round-robin order, and runs the spawn sequence: allocate a free thread,
// drive the regfile init bus for one cycle, then activate the thread.
// Kill removes a thread from the active set.
module trd_sched #(
  parameter int NUM_TRD = 8,
  parameter int TRD_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               spawn_req,
  input  logic [31:0]        spawn_arg,
  output logic               spawn_ack,
  output logic               spawn_nack,
  output logic [TRD_W-1:0]   spawn_trd,
  input  logic               kill_vld,
  input  logic [TRD_W-1:0]   kill_trd,
  output logic               init,
  output logic [TRD_W-1:0]   new_trd,
  output logic [31:0]        init_data,
  output logic               issue_vld,
  output logic [TRD_W-1:0]   issue_trd,
  output logic [NUM_TRD-1:0] active_mask,
  output logic               all_idle
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_ACT  = 2'd2
  } state_t;

  // Spawn FSM state and registered outputs
  state_t             r_state;
  logic [NUM_TRD-1:0] r_reserved;
  logic               r_init;
  logic [TRD_W-1:0]   r_new_trd;
  logic [31:0]        r_init_data;
  logic               r_spawn_ack;
  logic               r_spawn_nack;
  logic [TRD_W-1:0]   r_spawn_trd;
  logic               r_all_idle;

  // Active set and issue state
  logic [NUM_TRD-1:0] r_active_mask;
  logic [TRD_W-1:0]   r_rr_ptr;
  logic               r_issue_vld;
  logic [TRD_W-1:0]   r_issue_trd;

  // Combinational helpers
  logic [NUM_TRD-1:0] w_free;
  logic [TRD_W-1:0]   w_free_idx;
  logic               w_accept;
  logic               w_nack;
  logic               w_idle_nxt;
  logic [NUM_TRD-1:0] w_kill_bit;
  logic [NUM_TRD-1:0] w_act_bit;
  logic [NUM_TRD-1:0] w_mask_nxt;
  logic               w_rr_found;
  logic [TRD_W-1:0]   w_rr_nxt;

  // Allocation uses the mask before any same-cycle kill, so a thread being
  // killed this cycle is never handed out in the same cycle.
  assign w_free = ~r_active_mask & ~r_reserved;

  // A held request is not judged again in the cycle its nack is visible;
  // the requester drops spawn_req on seeing the nack.
  assign w_accept = (r_state == S_IDLE) && spawn_req && !r_spawn_nack && (|w_free);
  assign w_nack   = (r_state == S_IDLE) && spawn_req && !r_spawn_nack && !(|w_free);

  // FSM is back in S_IDLE after this edge when it stays idle or leaves S_ACT.
  assign w_idle_nxt = ((r_state == S_IDLE) && !w_accept) || (r_state == S_ACT);

  // Reserved threads are not active, but masking them keeps kill from ever
  // racing the activation of a thread mid-spawn.
  assign w_kill_bit = kill_vld ? ((NUM_TRD'(1) << kill_trd) & ~r_reserved) : '0;
  assign w_act_bit  = (r_state == S_ACT) ? (NUM_TRD'(1) << r_new_trd) : '0;
  assign w_mask_nxt = (r_active_mask & ~w_kill_bit) | w_act_bit;

  // Lowest-index free thread (scan from the top so the lowest wins).
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    w_free_idx = '0;
    for (int i = NUM_TRD - 1; i >= 0; i--) begin
      if (w_free[i]) w_free_idx = TRD_W'(i);
    end
  end

  // Round-robin search: first active thread after rr_ptr, wrapping, with
  // rr_ptr itself checked last so a lone active thread issues every cycle.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_nxt   = r_rr_ptr;
    for (int i = 1; i <= NUM_TRD; i++) begin
      if (!w_rr_found && r_active_mask[r_rr_ptr + TRD_W'(i)]) begin
        w_rr_found = 1'b1;
        w_rr_nxt   = r_rr_ptr + TRD_W'(i);
      end
    end
  end

  // Active-set update: kill clears, S_ACT sets; thread 0 boots active.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_active_mask <= NUM_TRD'(1);
    end else begin
      r_active_mask <= w_mask_nxt;
    end
  end

  // Issue stage: registered round-robin pick, frozen entirely under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_vld <= 1'b0;
      r_issue_trd <= '0;
      r_rr_ptr    <= TRD_W'(NUM_TRD - 1);
    end else if (!stall) begin
      r_issue_vld <= w_rr_found;
      if (w_rr_found) begin
        r_issue_trd <= w_rr_nxt;
        r_rr_ptr    <= w_rr_nxt;
      end
    end
  end

  // Spawn FSM: S_IDLE -> S_INIT (init bus + ack) -> S_ACT (activate) -> S_IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_reserved   <= '0;
      r_init       <= 1'b0;
      r_new_trd    <= '0;
      r_init_data  <= '0;
      r_spawn_ack  <= 1'b0;
      r_spawn_nack <= 1'b0;
      r_spawn_trd  <= '0;
      r_all_idle   <= 1'b0;
    end else begin
      r_init       <= 1'b0;
      r_spawn_ack  <= 1'b0;
      r_spawn_nack <= 1'b0;
      r_all_idle   <= (w_mask_nxt == '0) && w_idle_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_INIT;
            r_reserved  <= r_reserved | (NUM_TRD'(1) << w_free_idx);
            r_init      <= 1'b1;
            r_new_trd   <= w_free_idx;
            r_init_data <= spawn_arg;
            r_spawn_ack <= 1'b1;
            r_spawn_trd <= w_free_idx;
          end else if (w_nack) begin
            r_spawn_nack <= 1'b1;
          end
        end
        S_INIT: begin
          r_state <= S_ACT;
        end
        S_ACT: begin
          // Regfile write has landed; hand the thread over to the active set.
          r_reserved <= r_reserved & ~w_act_bit;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign spawn_ack   = r_spawn_ack;
  assign spawn_nack  = r_spawn_nack;
  assign spawn_trd   = r_spawn_trd;
  assign init        = r_init;
  assign new_trd     = r_new_trd;
  assign init_data   = r_init_data;
  assign issue_vld   = r_issue_vld;
  assign issue_trd   = r_issue_trd;
  assign active_mask = r_active_mask;
  assign all_idle    = r_all_idle;

endmodule
